// File: rtl/powerup_dropper.sv
// Power-up spawner: falling tokens, catch/miss detection against the paddle,
// and per-effect frame timers. One pu_slot instance tracks one falling token.

module pu_slot #(
   parameter int FALL_SPEED    = 5,
   parameter int PU_SIZE       = 10,
   parameter int SCREEN_BOTTOM = 479
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic       clear_i,
   input  logic       enable_i,
   input  logic [9:0] paddle_x_i,
   input  logic [9:0] paddle_y_i,
   input  logic [9:0] paddle_size_i,
   input  logic       consume_i,
   input  logic       load_i,
   input  logic [9:0] load_x_i,
   input  logic [2:0] load_type_i,
   output logic       valid_o,
   output logic [9:0] x_o,
   output logic [9:0] y_o,
   output logic [2:0] type_o,
   output logic       hit_o
);
   localparam logic [10:0] SZ     = 11'(PU_SIZE);
   localparam logic [9:0]  STEP   = 10'(FALL_SPEED);
   localparam logic [9:0]  BOTTOM = 10'(SCREEN_BOTTOM);

   logic        valid_q, valid_d;
   logic [9:0]  x_q, x_d, y_q, y_d;
   logic [2:0]  type_q, type_d;
   logic [10:0] tx, ty, px, py, pr;
   logic        miss;

   // 11-bit sums so edges near 1023 never wrap
   assign tx = {1'b0, x_q};
   assign ty = {1'b0, y_q};
   assign px = {1'b0, paddle_x_i};
   assign py = {1'b0, paddle_y_i};
   assign pr = {1'b0, paddle_x_i} + {1'b0, paddle_size_i};

   assign hit_o = valid_q && (ty + SZ >= py) && (ty <= py) && (tx + SZ >= px) && (tx <= pr);
   assign miss  = valid_q && !consume_i && (y_q >= BOTTOM);

   always_comb begin
      valid_d = valid_q;
      x_d     = x_q;
      y_d     = y_q;
      type_d  = type_q;
      if (clear_i) begin
         valid_d = 1'b0;
         x_d     = '0;
         y_d     = '0;
         type_d  = '0;
      end else if (enable_i) begin
         if (consume_i || miss) valid_d = 1'b0;
         else if (valid_q)      y_d = y_q + STEP;
         // load is only offered to slots that were empty at frame start
         if (load_i) begin
            valid_d = 1'b1;
            x_d     = load_x_i;
            y_d     = '0;
            type_d  = load_type_i;
         end
      end
   end

   always_ff @(posedge frame_clk or negedge Reset) begin
      if (!Reset) begin
         valid_q <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         type_q  <= '0;
      end else begin
         valid_q <= valid_d;
         x_q     <= x_d;
         y_q     <= y_d;
         type_q  <= type_d;
      end
   end

   assign valid_o = valid_q;
   assign x_o     = x_q;
   assign y_o     = y_q;
   assign type_o  = type_q;
endmodule

module powerup_dropper #(
   parameter int          NUM_SLOTS       = 4,
   parameter int          NUM_TYPES       = 6,
   parameter int          SPAWN_INTERVAL  = 25,
   parameter int          FIRST_THRESHOLD = 10,
   parameter int          FALL_SPEED      = 5,
   parameter int          PU_SIZE         = 10,
   parameter int          SCREEN_BOTTOM   = 479,
   parameter int          LANE_COUNT      = 10,
   parameter int          LANE_X0         = 26,
   parameter int          LANE_STEP       = 63,
   parameter int          EFFECT_FRAMES   = 600,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic                      frame_clk,
   input  logic                      Reset,
   input  logic                      clear,
   input  logic                      enable,
   input  logic [10:0]               score,
   input  logic [9:0]                paddle_x,
   input  logic [9:0]                paddle_y,
   input  logic [9:0]                paddle_size,
   output logic [NUM_SLOTS-1:0]      pu_valid,
   output logic [NUM_SLOTS*10-1:0]   pu_x,
   output logic [NUM_SLOTS*10-1:0]   pu_y,
   output logic [NUM_SLOTS*3-1:0]    pu_type,
   output logic [NUM_TYPES-1:0]      effect_on,
   output logic                      catch_pulse,
   output logic                      spawn_drop
);
   localparam int LIFE = NUM_TYPES - 1;
   localparam int TW   = $clog2(EFFECT_FRAMES + 1);

   logic [NUM_SLOTS-1:0]             valid, hit, consume, first_free, load;
   logic [NUM_SLOTS-1:0][9:0]        x_v, y_v;
   logic [NUM_SLOTS-1:0][2:0]        type_v;
   logic [2:0]                       ctype, new_type;
   logic [7:0]                       lane;
   logic [9:0]                       lane_x;
   logic                             spawn_req;
   logic [15:0]                      lfsr_q, lfsr_d;
   logic [10:0]                      thr_q, thr_d;
   logic [LIFE-1:0][TW-1:0]          timer_q, timer_d;
   logic                             life_q, life_d;
   logic [NUM_TYPES-1:0]             eff_q, eff_d;
   logic                             catch_q, catch_d, drop_q, drop_d;

   function automatic logic [10:0] sat_add(input logic [10:0] a);
      logic [11:0] s;
      s = {1'b0, a} + 12'(SPAWN_INTERVAL);
      return s[11] ? 11'h7FF : s[10:0];
   endfunction

   function automatic int partner(input int t);
      case (t)
         0: return 1;
         1: return 0;
         3: return 4;
         4: return 3;
         default: return -1;
      endcase
   endfunction

   for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
      pu_slot #(
         .FALL_SPEED(FALL_SPEED), .PU_SIZE(PU_SIZE), .SCREEN_BOTTOM(SCREEN_BOTTOM)
      ) u_slot (
         .frame_clk     (frame_clk),
         .Reset         (Reset),
         .clear_i       (clear),
         .enable_i      (enable),
         .paddle_x_i    (paddle_x),
         .paddle_y_i    (paddle_y),
         .paddle_size_i (paddle_size),
         .consume_i     (consume[g]),
         .load_i        (load[g]),
         .load_x_i      (lane_x),
         .load_type_i   (new_type),
         .valid_o       (valid[g]),
         .x_o           (x_v[g]),
         .y_o           (y_v[g]),
         .type_o        (type_v[g]),
         .hit_o         (hit[g])
      );
   end

   // Lowest catching slot wins; lowest empty slot takes a spawn.
   always_comb begin
      consume = '0;
      ctype   = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--)
         if (hit[i]) begin
            consume    = '0;
            consume[i] = 1'b1;
            ctype      = type_v[i];
         end
   end

   always_comb begin
      first_free = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--)
         if (!valid[i]) begin
            first_free    = '0;
            first_free[i] = 1'b1;
         end
   end

   assign lane      = 8'(32'(lfsr_q[7:0]) % LANE_COUNT);
   assign lane_x    = 10'(LANE_X0 + 32'(lane) * LANE_STEP);
   assign new_type  = 3'(32'(lfsr_q[15:8]) % NUM_TYPES);
   assign spawn_req = enable && !clear && (score >= thr_q);
   assign load      = spawn_req ? first_free : '0;
   assign lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

   always_comb begin
      timer_d = timer_q;
      life_d  = life_q;
      eff_d   = eff_q;
      thr_d   = thr_q;
      catch_d = 1'b0;
      drop_d  = 1'b0;
      if (clear) begin
         timer_d = '0;
         life_d  = 1'b0;
         eff_d   = '0;
         thr_d   = sat_add(score);
      end else if (enable) begin
         // effect levels trail the timers by one frame
         for (int t = 0; t < LIFE; t++) begin
            eff_d[t] = (timer_q[t] != '0);
            if (timer_q[t] != '0) timer_d[t] = timer_q[t] - TW'(1);
         end
         eff_d[LIFE] = life_q;
         life_d      = 1'b0;
         catch_d     = |hit;
         if (|hit) begin
            if (int'(ctype) == LIFE) life_d = 1'b1;
            for (int t = 0; t < LIFE; t++)
               if (int'(ctype) == t)               timer_d[t] = TW'(EFFECT_FRAMES);
               else if (partner(int'(ctype)) == t) timer_d[t] = '0;
         end
         if (spawn_req) begin
            thr_d  = sat_add(thr_q);
            drop_d = &valid;
         end
      end
   end

   always_ff @(posedge frame_clk or negedge Reset) begin
      if (!Reset) begin
         lfsr_q  <= LFSR_SEED;
         thr_q   <= 11'(FIRST_THRESHOLD);
         timer_q <= '0;
         life_q  <= 1'b0;
         eff_q   <= '0;
         catch_q <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         lfsr_q  <= lfsr_d;
         thr_q   <= thr_d;
         timer_q <= timer_d;
         life_q  <= life_d;
         eff_q   <= eff_d;
         catch_q <= catch_d;
         drop_q  <= drop_d;
      end
   end

   assign pu_valid    = valid;
   assign pu_x        = x_v;
   assign pu_y        = y_v;
   assign pu_type     = type_v;
   assign effect_on   = eff_q;
   assign catch_pulse = catch_q;
   assign spawn_drop  = drop_q;
endmodule
